// File: rtl/splitter_pkg.sv
// Shared widths and lane numbering for the word splitter.
// Lane 0 is the most-significant byte of the word in normal order.
package splitter_pkg;
  localparam int DATA_W    = 32;
  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;
  localparam int LANE_MSB  = 0;
  localparam int LANE_LSB  = 3;

  typedef logic [LANE_W-1:0]               lane_t;
  typedef lane_t [NUM_LANES-1:0]           lanes_t;
endpackage

// File: rtl/splitter_if.sv
// Word-in / four-lanes-out bus of the splitter.
// No ready signal: the consumer can never stall the producer.
interface splitter_if;
  import splitter_pkg::*;

  logic [DATA_W-1:0] A;
  logic              in_valid;
  logic              swap;
  lane_t             O1;
  lane_t             O2;
  lane_t             O3;
  lane_t             O4;
  logic              out_valid;

  modport master (output A, in_valid, swap, input O1, O2, O3, O4, out_valid);
  modport slave  (input A, in_valid, swap, output O1, O2, O3, O4, out_valid);
endinterface

// File: rtl/splitter_byte_lane_mux.sv
// Combinational byte-lane steering: lane 0 takes the top byte, or the bottom byte when swapped.
// Zero latency, no state, no backpressure.
module byte_lane_mux
  import splitter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic              swap,
  output lanes_t            lanes
);

  always_comb begin
    lanes = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (swap)
        lanes[i] = a[i*LANE_W +: LANE_W];
      else
        lanes[i] = a[DATA_W-1-i*LANE_W -: LANE_W];
    end
  end

endmodule

// File: rtl/splitter.sv
// Registered word splitter: captures A on in_valid and presents its bytes on O1..O4.
// One cycle latency, one word per cycle, never stalls; outputs come straight from flops.
module splitter
  import splitter_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  splitter_if.slave bus
);

  lanes_t lanes_d;
  lanes_t lanes_q;
  logic   valid_q;

  byte_lane_mux u_mux (
    .a     (bus.A),
    .swap  (bus.swap),
    .lanes (lanes_d)
  );

  // Reset wins over a simultaneous capture so a word arriving with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      lanes_q <= '0;
      valid_q <= 1'b0;
    end else if (bus.in_valid) begin
      lanes_q <= lanes_d;
      valid_q <= 1'b1;
    end
  end

  assign bus.O1        = lanes_q[LANE_MSB];
  assign bus.O2        = lanes_q[LANE_MSB+1];
  assign bus.O3        = lanes_q[LANE_LSB-1];
  assign bus.O4        = lanes_q[LANE_LSB];
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_splitter.sv
// Directed vector bench for splitter: one table row per clock edge, plus a few hand sequences.
module tb_splitter;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  splitter_if bus ();

  splitter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic        sw;
    logic [31:0] a;
    logic [31:0] exp_o;
    logic        exp_v;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] exp_o, input logic exp_v);
    check({tag, " lanes"}, {bus.O1, bus.O2, bus.O3, bus.O4}, exp_o);
    check({tag, " out_valid"}, {31'd0, bus.out_valid}, {31'd0, exp_v});
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'hDCF00731, 32'hDCF00731, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'hDCF00731, 32'h3107F0DC, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h12345678, 32'h12345678, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'hAAAAAAAA, 32'h12345678, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'hAAAAAAAA, 32'h12345678, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'hAAAAAAAA, 32'h12345678, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'hAAAAAAAA, 32'h12345678, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'hAAAAAAAA, 32'h12345678, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h01020304, 32'h01020304, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 32'hA0B0C0D0, 32'hA0B0C0D0, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 32'h55667788, 32'h00000000, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h55667788, 32'h00000000, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 32'hA0B0C0D0, 32'hD0C0B0A0, 1'b1};

    reset        = 1'b1;
    bus.A        = '0;
    bus.in_valid = 1'b0;
    bus.swap     = 1'b0;
    @(negedge clk);

    // Each row is driven at a falling edge and checked at the next falling edge.
    for (int i = 0; i < 15; i++) begin
      reset        = vecs[i].rst;
      bus.in_valid = vecs[i].iv;
      bus.swap     = vecs[i].sw;
      bus.A        = vecs[i].a;
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_o, vecs[i].exp_v);
    end

    // Outputs must not follow A before the capturing edge.
    bus.A        = 32'h11223344;
    bus.in_valid = 1'b1;
    bus.swap     = 1'b0;
    #1;
    check_outputs("no_comb_path", 32'hD0C0B0A0, 1'b1);
    @(negedge clk);
    check_outputs("post_comb_capture", 32'h11223344, 1'b1);

    // Alternating swap on consecutive edges.
    bus.A    = 32'hCAFEF00D;
    bus.swap = 1'b1;
    @(negedge clk);
    check_outputs("alt_swap1", 32'h0DF0FECA, 1'b1);
    bus.swap = 1'b0;
    @(negedge clk);
    check_outputs("alt_swap0", 32'hCAFEF00D, 1'b1);

    // Reset with idle input, then idle cycles: out_valid stays low.
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_outputs("idle_reset", 32'h00000000, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("idle_after_reset", 32'h00000000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
